alu_share_ctrl: RTL and testbench

//  Shares one instance of the parameterized ALU (alu #(WIDTH)) between two requesters.

---
 rtl/alu_share_ctrl.sv | 162 ++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Two-requester front end for a single shared ALU: round-robin grant, one op in flight,
// registered result/flag response tagged with the requester ID.

module alu #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             sign,
    output logic             illegal
);
    // ext[WIDTH] carries the carry/borrow or the bit shifted out
    logic [WIDTH:0] ext;

    always_comb begin
        ext     = '0;
        illegal = 1'b0;
        case (opcode)
            4'd0:    ext = {1'b0, a} + {1'b0, b};
            4'd1:    ext = {1'b0, a} - {1'b0, b};
            4'd2:    ext = {1'b0, a & b};
            4'd3:    ext = {1'b0, a | b};
            4'd4:    ext = {1'b0, a ^ b};
            4'd5:    ext = {1'b0, ~a};
            4'd6:    ext = {a, 1'b0};
            4'd7:    ext = {a[0], 1'b0, a[WIDTH-1:1]};
            4'd8:    ext = {1'b0, a} + (WIDTH+1)'(1);
            4'd9:    ext = {1'b0, a} - (WIDTH+1)'(1);
            default: illegal = 1'b1;
        endcase
        result = ext[WIDTH-1:0];
        carry  = ext[WIDTH];
        sign   = ext[WIDTH-1];
        zero   = !illegal && (ext[WIDTH-1:0] == '0);
    end
endmodule

module alu_share_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_opcode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_opcode,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             rsp_sign,
    output logic             rsp_illegal,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);
    // Handshakes: a request transfers on a rising edge where reqN_valid && reqN_ready;
    // a response transfers on a rising edge where rsp_valid && rsp_ready, and rsp_*
    // stay frozen while rsp_valid is high and rsp_ready is low.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_next;
    logic             last_grant;
    logic [WIDTH-1:0] op_a, op_b;
    logic [3:0]       op_code;
    logic             op_id;
    logic             grant0, grant1;
    logic             hs0, hs1;

    logic [WIDTH-1:0] alu_result;
    logic             alu_zero, alu_carry, alu_sign, alu_illegal;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a       (op_a),
        .b       (op_b),
        .opcode  (op_code),
        .result  (alu_result),
        .zero    (alu_zero),
        .carry   (alu_carry),
        .sign    (alu_sign),
        .illegal (alu_illegal)
    );

    // On a tie the requester that did not win last time goes first
    always_comb begin
        grant1 = req1_valid && (!req0_valid || !last_grant);
        grant0 = req0_valid && !grant1;
    end

    always_comb begin
        req0_ready = (state == IDLE) && grant0;
        req1_ready = (state == IDLE) && grant1;
        hs0        = req0_ready && req0_valid;
        hs1        = req1_ready && req1_valid;
        rsp_valid  = (state == RESP);
        busy       = (state != IDLE);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (hs0 || hs1) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            op_a        <= '0;
            op_b        <= '0;
            op_code     <= '0;
            op_id       <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_carry   <= 1'b0;
            rsp_sign    <= 1'b0;
            rsp_illegal <= 1'b0;
            ops_done    <= '0;
        end else begin
            state <= state_next;
            if (hs0 || hs1) begin
                op_a       <= hs1 ? req1_a : req0_a;
                op_b       <= hs1 ? req1_b : req0_b;
                op_code    <= hs1 ? req1_opcode : req0_opcode;
                op_id      <= hs1;
                last_grant <= hs1;
            end
            if (state == EXEC) begin
                rsp_id      <= op_id;
                rsp_result  <= alu_illegal ? '0 : alu_result;
                rsp_zero    <= alu_illegal ? 1'b0 : alu_zero;
                rsp_carry   <= alu_illegal ? 1'b0 : alu_carry;
                rsp_sign    <= alu_illegal ? 1'b0 : alu_sign;
                rsp_illegal <= alu_illegal;
            end
            if (state == RESP && rsp_ready) begin
                ops_done <= ops_done + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed cases plus random two-requester traffic checked
// against an arithmetic reference model through an expected-response queue.
module tb_alu_share_ctrl;
    localparam int W  = 8;
    localparam int CW = 16;
    localparam int M  = 1 << W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]    req0_opcode = '0, req1_opcode = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_id, rsp_zero, rsp_carry, rsp_sign, rsp_illegal, busy;
    logic [W-1:0]  rsp_result;
    logic [CW-1:0] ops_done;

    alu_share_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_opcode(req0_opcode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_opcode(req1_opcode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .rsp_sign(rsp_sign), .rsp_illegal(rsp_illegal), .busy(busy),
        .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // {id, result, zero, carry, sign, illegal}
    logic [W+4:0]  exp_q[$];
    int            errors = 0;
    int            checks = 0;
    logic          tb_last = 1'b1;
    logic [CW-1:0] delivered = '0;
    int            rmode = 0;
    logic          prev_valid = 1'b0, prev_ready = 1'b0;
    logic [W+4:0]  snap = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W+4:0] model(input logic id, input logic [3:0] op,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        int ia, ib, r;
        logic c, ill, z;
        logic [W-1:0] res;
        ia = int'(a); ib = int'(b); c = 1'b0; ill = 1'b0;
        case (op)
            4'd0: begin r = ia + ib; c = (r >= M); end
            4'd1: begin r = ia - ib; c = (ia < ib); end
            4'd2: r = int'(a & b);
            4'd3: r = int'(a | b);
            4'd4: r = int'(a ^ b);
            4'd5: r = M - 1 - ia;
            4'd6: begin r = ia * 2; c = (ia >= M / 2); end
            4'd7: begin r = ia / 2; c = (ia % 2 == 1); end
            4'd8: begin r = ia + 1; c = (ia == M - 1); end
            4'd9: begin r = ia - 1; c = (ia == 0); end
            default: begin r = 0; ill = 1'b1; end
        endcase
        r   = ((r % M) + M) % M;
        res = r[W-1:0];
        z   = !ill && (r == 0);
        return {id, res, z, c, res[W-1], ill};
    endfunction

    task automatic drive(input logic id, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        logic rdy;
        @(posedge clk); #2;
        if (!id) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_opcode = op; end
        else     begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_opcode = op; end
        n = 0;
        forever begin
            @(negedge clk);
            rdy = id ? req1_ready : req0_ready;
            if (rdy) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL req%0d_timeout: ready never seen, expected within 200 cycles", id);
                break;
            end
        end
        @(posedge clk); #2;
        if (!id) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        delivered  = '0;
        tb_last    = 1'b1;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        #1;
        check("rst_outputs", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero,
                              rsp_carry, rsp_sign, rsp_illegal, busy}, 32'd0);
        check("rst_ops_done", 32'(ops_done), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Consumer side
    initial begin
        int stall;
        stall = 0;
        forever begin
            @(posedge clk); #2;
            case (rmode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (rsp_valid && stall < 5) begin rsp_ready = 1'b0; stall++; end
                    else begin rsp_ready = 1'b1; if (!rsp_valid) stall = 0; end
                end
            endcase
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic e0, e1;
        logic [W+4:0] got, exp;
        if (rst_n) begin
            got = {rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_sign, rsp_illegal};
            check("ops_done", 32'(ops_done), 32'(delivered));
            if (busy) check("ready_while_busy", {req0_ready, req1_ready}, 32'd0);
            if (!busy && (req0_valid || req1_valid)) begin
                if (req0_valid && req1_valid) e0 = (tb_last == 1'b1);
                else e0 = req0_valid;
                e1 = req1_valid && !e0;
                check("grant", {req0_ready, req1_ready}, {e0, e1});
            end
            if (prev_valid && !prev_ready) begin
                check("stall_valid", 32'(rsp_valid), 32'd1);
                check("stall_stable", 32'(got), 32'(snap));
            end
            if (req0_valid && req0_ready) begin
                exp_q.push_back(model(1'b0, req0_opcode, req0_a, req0_b));
                tb_last = 1'b0;
            end
            if (req1_valid && req1_ready) begin
                exp_q.push_back(model(1'b1, req1_opcode, req1_a, req1_b));
                tb_last = 1'b1;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_rsp: got %0h with no expected response", got);
                end else begin
                    exp = exp_q.pop_front();
                    check("rsp", 32'(got), 32'(exp));
                end
                delivered = delivered + 1'b1;
            end
            prev_valid = rsp_valid;
            prev_ready = rsp_ready;
            snap       = got;
        end
    end

    initial begin
        do_reset();
        // both requesters from reset: req0 first, then alternating
        fork
            begin drive(1'b0, 4'd1, 8'd10, 8'd5); drive(1'b0, 4'd0, 8'd1, 8'd2); end
            begin drive(1'b1, 4'd2, 8'd6, 8'd3);  drive(1'b1, 4'd3, 8'd9, 8'd6); end
        join
        wait_drain();
        drive(1'b0, 4'd0, 8'd10, 8'd5);
        drive(1'b1, 4'b1100, 8'd77, 8'd3);
        drive(1'b0, 4'd9, 8'd0, 8'd0);
        drive(1'b1, 4'd1, 8'd5, 8'd5);
        drive(1'b0, 4'd0, 8'hFF, 8'h01);
        drive(1'b1, 4'd6, 8'h81, 8'h00);
        drive(1'b0, 4'd7, 8'h03, 8'h00);
        drive(1'b1, 4'd8, 8'hFF, 8'h00);
        wait_drain();
        // consumer stalls each response for 5 cycles
        rmode = 2;
        drive(1'b0, 4'd4, 8'hA5, 8'h3C);
        drive(1'b1, 4'd5, 8'h0F, 8'h00);
        wait_drain();
        // random traffic from both sides, including illegal opcodes
        rmode = 1;
        fork
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                drive(1'b0, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
            end
            for (int j = 0; j < 30; j++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                drive(1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
            end
        join
        wait_drain();
        // reset while an op is executing
        rmode = 0;
        drive(1'b1, 4'd0, 8'd3, 8'd4);
        check("busy_exec", 32'(busy), 32'd1);
        do_reset();
        repeat (6) begin
            @(negedge clk);
            check("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        end
        fork
            drive(1'b0, 4'd0, 8'd20, 8'd22);
            drive(1'b1, 4'd1, 8'd20, 8'd22);
        join
        wait_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end
endmodule
